// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: timing master for the serial ADC link.
// Generates an active-low chip select and an idle-high serial clock framing
// NUM_SCLK sclk rising edges per conversion. One frame is started per trigger.
// The trigger comes from an internal sample-rate timer, or from a synchronised
// external trigger when ADC_SPI_CTRL_EXT_TRIG_EN is defined.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   enable     in   1 = trigger source active; 0 = timer held at reload / ext_trig ignored
//   ext_trig   in   external trigger (only with ADC_SPI_CTRL_EXT_TRIG_EN)
//   cs_adc     out  ADC chip select, active low
//   sclk_adc   out  ADC serial clock, idles high
//   busy       out  high while a frame (including quiet time) is in progress
//   frame_done out  one-cycle pulse at the end of each frame
//   overrun    out  one-cycle pulse when a trigger arrives while busy
module adc_spi_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int NUM_SCLK      = 16,
  parameter int QUIET_CYC     = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TMR_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
`ifdef ADC_SPI_CTRL_EXT_TRIG_EN
  input  logic ext_trig,
`endif
  output logic cs_adc,
  output logic sclk_adc,
  output logic busy,
  output logic frame_done,
  output logic overrun
);

  localparam int EDGE_W  = $clog2(NUM_SCLK + 1);
  localparam int DIV_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  QUIET_LAST = DIV_W'(QUIET_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(NUM_SCLK);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               tick;

`ifdef ADC_SPI_CTRL_EXT_TRIG_EN
  // Two flops synchronise ext_trig; the third holds the previous synchronised
  // value for rising-edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], ext_trig};
  end

  always_comb tick = enable & sync_q[1] & ~sync_q[2];
`else
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    tick  = 1'b0;
    tmr_d = tmr_q;
    if (!enable) begin
      tmr_d = TMR_RELOAD;
    end else if (tmr_q == '0) begin
      tmr_d = TMR_RELOAD;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= TMR_RELOAD;
    else     tmr_q <= tmr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (tick) begin
          state_d = SETUP;
          div_d   = '0;
          edge_d  = '0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            edge_d = edge_q + 1'b1;
          end else if (edge_q == EDGE_LAST) begin
            // Last high half-period finished: leave with sclk still high.
            state_d = QUIET;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      QUIET: begin
        sclk_d = 1'b1;
        if (div_q == QUIET_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    cs_d   = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
    done_d = (state_q == SHIFT) && (state_d == QUIET);
    // Any trigger outside IDLE (including the QUIET->IDLE cycle) is dropped.
    ovr_d  = tick && (state_q != IDLE);
  end

  assign cs_adc     = cs_q;
  assign sclk_adc   = sclk_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
module tb_adc_spi_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: SAMPLE_PERIOD=100
  logic rst = 1'b1, enable = 1'b0;
  logic cs_adc, sclk_adc, busy, frame_done, overrun;
  // Overrun DUT: SAMPLE_PERIOD=50
  logic rst2 = 1'b1, en2 = 1'b0;
  logic cs2, sclk2, busy2, fd2, ov2;

  adc_spi_ctrl #(.CLK_DIV(2), .NUM_SCLK(16), .QUIET_CYC(4), .SAMPLE_PERIOD(100), .TMR_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cs_adc(cs_adc), .sclk_adc(sclk_adc), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  adc_spi_ctrl #(.CLK_DIV(2), .NUM_SCLK(16), .QUIET_CYC(4), .SAMPLE_PERIOD(50), .TMR_W(16)) dut_ov (
    .clk(clk), .rst(rst2), .enable(en2),
    .cs_adc(cs2), .sclk_adc(sclk2), .busy(busy2),
    .frame_done(fd2), .overrun(ov2)
  );

  int checks = 0;
  int failures = 0;

  logic cs_tr [0:1100];
  logic sc_tr [0:1100];
  logic bz_tr [0:1100];
  logic fd_tr [0:1100];
  logic ov_tr [0:1100];

  task automatic test_reset();
    int bad;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_adc !== 1'b1)     begin failures++; $display("FAIL reset_cs got=%b exp=1", cs_adc); end
    checks++; if (sclk_adc !== 1'b1)   begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk_adc); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cs_adc !== 1'b1 || sclk_adc !== 1'b1 || busy !== 1'b0 ||
          frame_done !== 1'b0 || overrun !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL idle_disabled bad_cycles=%0d exp=0", bad); end
  endtask

  // Enable at a negedge; index k = sample after the k-th posedge with enable=1.
  task automatic capture_main(input int n);
    cs_tr[0] = cs_adc; sc_tr[0] = sclk_adc; bz_tr[0] = busy; fd_tr[0] = frame_done; ov_tr[0] = overrun;
    enable = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cs_tr[i] = cs_adc; sc_tr[i] = sclk_adc; bz_tr[i] = busy; fd_tr[i] = frame_done; ov_tr[i] = overrun;
    end
  endtask

  task automatic test_single_frame();
    int first_fall, low_cnt, rises, pat_bad, fd_cnt;
    logic exp_s;
    capture_main(1000);
    first_fall = -1;
    for (int i = 1; i <= 1000; i++)
      if (first_fall < 0 && cs_tr[i] === 1'b0 && cs_tr[i-1] === 1'b1) first_fall = i;
    checks++; if (first_fall !== 100) begin failures++; $display("FAIL first_cs_fall got=%0d exp=100", first_fall); end
    low_cnt = 0; rises = 0; pat_bad = 0; fd_cnt = 0;
    for (int i = 100; i < 200; i++) begin
      if (cs_tr[i] === 1'b0) low_cnt++;
      if (fd_tr[i] === 1'b1) fd_cnt++;
    end
    for (int i = 100; i <= 165; i++) begin
      if (sc_tr[i] === 1'b1 && sc_tr[i-1] === 1'b0) rises++;
      exp_s = (i < 102) ? 1'b1 : (((i - 102) / 2) % 2 == 1);
      if (sc_tr[i] !== exp_s) pat_bad++;
    end
    checks++; if (low_cnt !== 66) begin failures++; $display("FAIL cs_low_time got=%0d exp=66", low_cnt); end
    checks++; if (rises !== 16)   begin failures++; $display("FAIL sclk_rises got=%0d exp=16", rises); end
    checks++; if (pat_bad !== 0)  begin failures++; $display("FAIL sclk_pattern bad=%0d exp=0", pat_bad); end
    checks++; if (fd_cnt !== 1)   begin failures++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
    checks++; if (fd_tr[166] !== 1'b1 || cs_tr[166] !== 1'b1)
      begin failures++; $display("FAIL frame_done_pos fd=%b cs=%b exp=1,1", fd_tr[166], cs_tr[166]); end
    checks++; if (bz_tr[169] !== 1'b1 || bz_tr[170] !== 1'b0)
      begin failures++; $display("FAIL busy_tail b169=%b b170=%b exp=1,0", bz_tr[169], bz_tr[170]); end
  endtask

  task automatic test_periodic();
    int falls, misplaced, ov_cnt, fd_cnt, glitch;
    falls = 0; misplaced = 0; ov_cnt = 0; fd_cnt = 0; glitch = 0;
    for (int i = 1; i <= 1000; i++) begin
      if (cs_tr[i] === 1'b0 && cs_tr[i-1] === 1'b1) begin
        falls++;
        if (i % 100 != 0) misplaced++;
      end
      if (cs_tr[i] !== cs_tr[i-1] && (sc_tr[i] !== 1'b1 || sc_tr[i-1] !== 1'b1)) glitch++;
      if (ov_tr[i] === 1'b1) ov_cnt++;
      if (fd_tr[i] === 1'b1) fd_cnt++;
    end
    checks++; if (falls !== 10)    begin failures++; $display("FAIL periodic_falls got=%0d exp=10", falls); end
    checks++; if (misplaced !== 0) begin failures++; $display("FAIL periodic_spacing bad=%0d exp=0", misplaced); end
    checks++; if (ov_cnt !== 0)    begin failures++; $display("FAIL periodic_overrun got=%0d exp=0", ov_cnt); end
    checks++; if (fd_cnt !== 9)    begin failures++; $display("FAIL periodic_done got=%0d exp=9", fd_cnt); end
    checks++; if (glitch !== 0)    begin failures++; $display("FAIL sclk_high_at_cs_change bad=%0d exp=0", glitch); end
  endtask

  task automatic test_overrun();
    int ov_cnt, ov_bad, falls, fall_bad, rises, fd_cnt, low_cnt;
    rst2 = 1'b1; en2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    cs_tr[0] = cs2; sc_tr[0] = sclk2; ov_tr[0] = ov2;
    en2 = 1'b1;
    for (int i = 1; i <= 430; i++) begin
      @(negedge clk);
      cs_tr[i] = cs2; sc_tr[i] = sclk2; fd_tr[i] = fd2; ov_tr[i] = ov2;
    end
    ov_cnt = 0; ov_bad = 0; falls = 0; fall_bad = 0; rises = 0; fd_cnt = 0; low_cnt = 0;
    for (int i = 1; i <= 430; i++) begin
      if (ov_tr[i] === 1'b1) begin ov_cnt++; if (i % 100 != 0) ov_bad++; end
      if (cs_tr[i] === 1'b0 && cs_tr[i-1] === 1'b1) begin falls++; if (i % 100 != 50) fall_bad++; end
      if (cs_tr[i] === 1'b0) begin
        low_cnt++;
        if (sc_tr[i] === 1'b1 && sc_tr[i-1] === 1'b0) rises++;
      end
      if (fd_tr[i] === 1'b1) fd_cnt++;
    end
    checks++; if (ov_cnt !== 4)   begin failures++; $display("FAIL ovr_count got=%0d exp=4", ov_cnt); end
    checks++; if (ov_bad !== 0)   begin failures++; $display("FAIL ovr_position bad=%0d exp=0", ov_bad); end
    checks++; if (falls !== 4)    begin failures++; $display("FAIL ovr_frames got=%0d exp=4", falls); end
    checks++; if (fall_bad !== 0) begin failures++; $display("FAIL ovr_frame_pos bad=%0d exp=0", fall_bad); end
    checks++; if (rises !== 64)   begin failures++; $display("FAIL ovr_sclk_rises got=%0d exp=64", rises); end
    checks++; if (low_cnt !== 264) begin failures++; $display("FAIL ovr_cs_low got=%0d exp=264", low_cnt); end
    checks++; if (fd_cnt !== 4)   begin failures++; $display("FAIL ovr_done got=%0d exp=4", fd_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int n, rises;
    logic prev;
    rst = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    n = 0;
    while (cs_adc !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (cs_adc !== 1'b0) begin failures++; $display("FAIL mid_wait_cs timeout cs=%b exp=0", cs_adc); end
    rises = 0; n = 0; prev = sclk_adc;
    while (rises < 7 && n < 100) begin
      @(negedge clk); n++;
      if (sclk_adc === 1'b1 && prev === 1'b0) rises++;
      prev = sclk_adc;
    end
    checks++; if (rises !== 7) begin failures++; $display("FAIL mid_wait_rises got=%0d exp=7", rises); end
    repeat (2) @(negedge clk);
    checks++; if (sclk_adc !== 1'b0 || cs_adc !== 1'b0)
      begin failures++; $display("FAIL mid_pre_state sclk=%b cs=%b exp=0,0", sclk_adc, cs_adc); end
    rst = 1'b1;
    #1;
    checks++; if (cs_adc !== 1'b1 || sclk_adc !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL mid_async_reset cs=%b sclk=%b busy=%b exp=1,1,0", cs_adc, sclk_adc, busy); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (cs_adc !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (n !== 100) begin failures++; $display("FAIL mid_restart_delay got=%0d exp=100", n); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_periodic();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_ctrl.md
Name: adc_spi_ctrl

Overview:
- Timing master for the serial ADC link. Generates the chip-select and serial clock that the downstream ADC capture stage consumes (cs_adc, and its clk = sclk_adc).
- Starts one conversion frame per sample period from an internal rate timer, or from an external trigger when the optional feature is enabled.
- Reports frame completion and missed (overrun) sample triggers to the DSP control logic.

Parameters:
- CLK_DIV, 2: sclk half-period in clk cycles; legal range ≥1.
- NUM_SCLK, 16: sclk rising edges per frame; matches the 16-count capture stage.
- QUIET_CYC, 4: clk cycles cs_adc is held high after a frame before the next frame may start; legal range ≥1.
- SAMPLE_PERIOD, 1000: clk cycles between frame starts (sets the sample rate); legal range ≥2.
- TMR_W, 16: rate-timer width; must satisfy 2^TMR_W > SAMPLE_PERIOD.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  1 = sample-rate timer runs; 0 = timer held at reload.
- cs_adc  out  1  ADC chip select, active low; to ADC and capture stage.
- sclk_adc  out  1  ADC serial clock, idles high; also clocks the capture stage.
- busy  out  1  high while state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- overrun  out  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Reset (async, rst=1): cs_adc=1, sclk_adc=1, busy=0, frame_done=0, overrun=0, state=IDLE, rate timer=SAMPLE_PERIOD-1, edge counter=0, divider=0. Outputs take these values immediately on rst assertion, including mid-frame; no partial frame resumes after release.
- Outputs are registered; no combinational path from inputs to outputs.
- Rate timer, enable=1: decrements each clk. At 0 it reloads to SAMPLE_PERIOD-1 and asserts internal tick for one cycle. Period is exactly SAMPLE_PERIOD cycles.
- Rate timer, enable=0: timer held at SAMPLE_PERIOD-1. After enable rises, the first tick occurs SAMPLE_PERIOD cycles later. A frame already in progress always completes.
- States:
  - IDLE: cs_adc=1, sclk_adc=1. On tick, go to SETUP; cs_adc=0 from the next cycle.
  - SETUP: cs_adc=0, sclk_adc=1 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: sclk_adc toggles every CLK_DIV cycles, starting low (low CLK_DIV cycles, then high CLK_DIV cycles). The edge counter increments on each rising edge. After NUM_SCLK rising edges and the following high half-period, go to QUIET.
  - QUIET: cs_adc=1, sclk_adc=1 for QUIET_CYC cycles, then go to IDLE. frame_done=1 on the first QUIET cycle only.
- cs_adc low time per frame: CLK_DIV*(2*NUM_SCLK+1) cycles (66 at defaults).
- sclk_adc never glitches: changes only on clk edges, and is high whenever cs_adc changes.
- Tick while state ≠ IDLE: trigger is dropped, overrun pulses 1 cycle, the current frame is unaffected.
- Tick on the same cycle QUIET→IDLE: counts as busy (overrun); the frame is not started.
- Legal SAMPLE_PERIOD ≥ CLK_DIV*(2*NUM_SCLK+1)+QUIET_CYC+1; smaller values produce periodic overrun, which is not an error.
- Edge counter width: clog2(NUM_SCLK+1) bits; must not wrap within a frame.

Optional Feature:
- Macro ADC_SPI_CTRL_EXT_TRIG_EN.
- Defined: adds input port ext_trig (1 bit). Its rising edge, detected after a 2-flop synchronizer, replaces the internal tick. The rate timer is removed; enable gates ext_trig (ignored when enable=0). The overrun rules are unchanged.
- Undefined: no ext_trig port; triggering comes from the internal timer as described above.

Test Plan:
- Reset/idle (defaults, CLK_DIV=2, SAMPLE_PERIOD=100, QUIET_CYC=4): hold rst, then release with enable=0 for 500 cycles -> cs_adc=1, sclk_adc=1, busy=0, no pulses.
- Single frame: enable=1 at cycle 0 -> cs_adc falls at cycle 100; exactly 16 sclk rising edges, each low/high 2 cycles; cs_adc low 66 cycles; frame_done pulses once; busy low 4 cycles after cs_adc rises.
- Periodic rate: enable held 1000 cycles -> cs_adc falling edges exactly 100 cycles apart; overrun never asserts.
- Overrun: SAMPLE_PERIOD=50 -> each second tick pulses overrun; frames stay complete (16 edges) and never truncate.
- Reset mid-frame: assert rst after the 7th sclk rising edge -> cs_adc=1 and sclk_adc=1 in the same cycle; after release, the next frame begins SAMPLE_PERIOD cycles later.
- Ext trigger (macro defined): ext_trig pulses at cycles 10 and 40 -> frame starts 3–4 cycles after the first pulse; the second pulse arrives while busy -> overrun pulse, no second frame.
